// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT schedule controller.
// W is the shared 32-bit width used by helpers and the cycle counter.
package ntt_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Open a zero bit at position s, shifting bits >= s up by one.
  function automatic logic [W-1:0] insert_zero_bit(
    input logic [W-1:0] c,
    input logic [W-1:0] s
  );
    logic [W-1:0] lo;
    lo = c & ((W'(1) << s) - W'(1));
    return ((c >> s) << (s + W'(1))) | lo;
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Reset-cleared shift register carrying {valid, addr_a, addr_b}.
// Aligns write-back addresses with the read + butterfly latency.
module ntt_addr_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  output logic          valid_o,
  output logic [AW-1:0] a_o,
  output logic [AW-1:0] b_o
);

  logic [DEPTH-1:0] v_q;
  logic [AW-1:0]    a_q [DEPTH];
  logic [AW-1:0]    b_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q[0] <= valid_i;
      a_q[0] <= a_i;
      b_q[0] <= b_i;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign a_o     = a_q[DEPTH-1];
  assign b_o     = b_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 NTT/iNTT schedule controller with drained stages.
// Optional busy-cycle counter behind NTT_STAGE_CTRL_PERF_EN.
module ntt_stage_ctrl
  import ntt_pkg::*;
#(
  parameter  int N      = 256,
  parameter  int RD_LAT = 1,
  parameter  int BF_LAT = 1,
  localparam int LOGN   = $clog2(N),
  localparam int SW     = $clog2(LOGN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode_in,
  output logic            busy,
  output logic            done,
  output logic            iNTT_mode,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
`ifdef NTT_STAGE_CTRL_PERF_EN
  output logic [W-1:0]    cycles,
`endif
  output logic [SW-1:0]   stage
);

  localparam int DL = RD_LAT + BF_LAT;
  localparam int DW = (DL > 1) ? $clog2(DL) : 1;
  localparam int CW = LOGN - 1;

  ctrl_state_t   state_q;
  logic [CW-1:0] c_q;
  logic [SW-1:0] s_q;
  logic [DW-1:0] d_q;
  logic          mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            mode_q  <= mode_in;
            c_q     <= '0;
            s_q     <= '0;
          end
        end
        RUN: begin
          if (c_q == '1) begin
            state_q <= DRAIN;
            d_q     <= '0;
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        DRAIN: begin
          if (d_q == DW'(DL - 1)) begin
            if (s_q == SW'(LOGN - 1)) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
              s_q     <= s_q + SW'(1);
              c_q     <= '0;
            end
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rd_en     = (state_q == RUN);
  assign iNTT_mode = mode_q;
  assign stage     = s_q;

  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [CW-1:0]   k;
  logic [CW-1:0]   tw;

  always_comb begin
    addr_a = LOGN'(insert_zero_bit(W'(c_q), W'(s_q)));
    addr_b = addr_a | (LOGN'(1) << s_q);
    k      = c_q & ((CW'(1) << s_q) - CW'(1));
    tw     = k << (SW'(CW) - s_q);
  end

  // Addresses are forced to zero when idle so the delay line and
  // the write port see clean zeros outside of RUN.
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_b : '0;
  assign tw_idx    = rd_en ? tw : '0;

  ntt_addr_delay #(
    .DEPTH (DL),
    .AW    (LOGN)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .valid_i (rd_en),
    .a_i     (rd_addr_a),
    .b_i     (rd_addr_b),
    .valid_o (wr_en),
    .a_o     (wr_addr_a),
    .b_o     (wr_addr_b)
  );

`ifdef NTT_STAGE_CTRL_PERF_EN
  logic [W-1:0] cyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if (state_q == IDLE && start) begin
      cyc_q <= '0;
    end else if (busy) begin
      cyc_q <= cyc_q + W'(1);
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed, table-driven bench for ntt_stage_ctrl at N=8.
module tb_ntt_stage_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode_in;
  logic       busy;
  logic       done;
  logic       iNTT_mode;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_idx;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
  logic [2:0] stage;
`ifdef NTT_STAGE_CTRL_PERF_EN
  logic [31:0] cycles;
`endif

  always #5 clk = ~clk;

  ntt_stage_ctrl #(
    .N      (N),
    .RD_LAT (1),
    .BF_LAT (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode_in   (mode_in),
    .busy      (busy),
    .done      (done),
    .iNTT_mode (iNTT_mode),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
`ifdef NTT_STAGE_CTRL_PERF_EN
    .cycles    (cycles),
`endif
    .stage     (stage)
  );

  typedef struct packed {
    logic       mode;
    logic       rd;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic       wr;
    logic [2:0] wa;
    logic [2:0] wb;
    logic       busy;
    logic       done;
    logic [2:0] stage;
  } obs_t;

  obs_t vec [20];
  int   nvec = 0;
  int   nmis = 0;
  logic pend [8] = '{default: 1'b0};
  logic mon_en = 1'b0;

  function automatic obs_t mk(
    input logic rd, input int a, input int b, input int tw,
    input logic wr, input int wa, input int wb,
    input logic bz, input logic dn, input int st
  );
    obs_t o;
    o.mode  = 1'b0;
    o.rd    = rd;
    o.a     = 3'(a);
    o.b     = 3'(b);
    o.tw    = 2'(tw);
    o.wr    = wr;
    o.wa    = 3'(wa);
    o.wb    = 3'(wb);
    o.busy  = bz;
    o.done  = dn;
    o.stage = 3'(st);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.mode  = iNTT_mode;
    o.rd    = rd_en;
    o.a     = rd_addr_a;
    o.b     = rd_addr_b;
    o.tw    = tw_idx;
    o.wr    = wr_en;
    o.wa    = wr_addr_a;
    o.wb    = wr_addr_b;
    o.busy  = busy;
    o.done  = done;
    o.stage = stage;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %p, expected %p", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    obs_t z;
    z = '0;
    check(name, sample(), z);
  endtask

  // A read must never hit an address whose earlier read is still
  // waiting for its write-back (same-cycle write counts as too early).
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) pend[i] = 1'b0;
    end else if (mon_en) begin
      if (rd_en) begin
        nvec++;
        if (pend[rd_addr_a] || pend[rd_addr_b]) begin
          nmis++;
          $display("FAIL raw_hazard: read a=%0d b=%0d, pending a=%0b b=%0b, required none",
                   rd_addr_a, rd_addr_b, pend[rd_addr_a], pend[rd_addr_b]);
        end
      end
      if (wr_en) begin
        pend[wr_addr_a] = 1'b0;
        pend[wr_addr_b] = 1'b0;
      end
      if (rd_en) begin
        pend[rd_addr_a] = 1'b1;
        pend[rd_addr_b] = 1'b1;
      end
    end
  end

  task automatic run_sched(input logic m, input logic poke, input string tag);
    obs_t exp;
    @(posedge clk); #1;
    start   = 1'b1;
    mode_in = m;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = poke && (k == 3 || k == 12);
      if (poke && k == 3) mode_in = ~m;
      @(negedge clk);
      exp      = vec[k-1];
      exp.mode = m;
      check($sformatf("%s_c%0d", tag, k), sample(), exp);
    end
    start = 1'b0;
`ifdef NTT_STAGE_CTRL_PERF_EN
    nvec++;
    if (cycles !== 32'd18) begin
      nmis++;
      $display("FAIL %s_cycles: got %0d, expected 18", tag, cycles);
    end
`endif
  endtask

  task automatic mid_reset();
    obs_t exp;
    @(posedge clk); #1;
    start   = 1'b1;
    mode_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      exp      = vec[k-1];
      exp.mode = 1'b1;
      check($sformatf("pre_reset_c%0d", k), sample(), exp);
    end
    #1 reset = 1'b1;
    #1 check_zero("mid_reset_async");
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_held");
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("post_reset_idle");
    end
  endtask

  initial begin
    vec[0]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    vec[1]  = mk(1, 2, 3, 0, 0, 0, 0, 1, 0, 0);
    vec[2]  = mk(1, 4, 5, 0, 1, 0, 1, 1, 0, 0);
    vec[3]  = mk(1, 6, 7, 0, 1, 2, 3, 1, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 1, 4, 5, 1, 0, 0);
    vec[5]  = mk(0, 0, 0, 0, 1, 6, 7, 1, 0, 0);
    vec[6]  = mk(1, 0, 2, 0, 0, 0, 0, 1, 0, 1);
    vec[7]  = mk(1, 1, 3, 2, 0, 0, 0, 1, 0, 1);
    vec[8]  = mk(1, 4, 6, 0, 1, 0, 2, 1, 0, 1);
    vec[9]  = mk(1, 5, 7, 2, 1, 1, 3, 1, 0, 1);
    vec[10] = mk(0, 0, 0, 0, 1, 4, 6, 1, 0, 1);
    vec[11] = mk(0, 0, 0, 0, 1, 5, 7, 1, 0, 1);
    vec[12] = mk(1, 0, 4, 0, 0, 0, 0, 1, 0, 2);
    vec[13] = mk(1, 1, 5, 1, 0, 0, 0, 1, 0, 2);
    vec[14] = mk(1, 2, 6, 2, 1, 0, 4, 1, 0, 2);
    vec[15] = mk(1, 3, 7, 3, 1, 1, 5, 1, 0, 2);
    vec[16] = mk(0, 0, 0, 0, 1, 2, 6, 1, 0, 2);
    vec[17] = mk(0, 0, 0, 0, 1, 3, 7, 1, 0, 2);
    vec[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    vec[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    reset   = 1'b0;
    start   = 1'b0;
    mode_in = 1'b0;
    #1 reset = 1'b1;
    #1 check_zero("reset_init");
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    run_sched(1'b0, 1'b0, "fwd");
    run_sched(1'b1, 1'b1, "inv");
    mid_reset();
    run_sched(1'b0, 1'b0, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
# ntt_stage_ctrl

In-place radix-2 NTT/iNTT schedule controller. It is the initiator side of the butterfly datapath: it issues coefficient-RAM read addresses and twiddle-ROM indices, and latches and drives the transform direction. It then writes results back to the same addresses after the read and butterfly pipeline latency. It runs log2(N) stages of N/2 butterflies, one butterfly per cycle, and drains the pipeline between stages so that no read precedes the write it depends on.

## Interface
- N, 256, transform length; power of two, ≥4
- RD_LAT, 1, coefficient-RAM and twiddle-ROM read latency (cycles)
- BF_LAT, 1, butterfly input-to-output latency (cycles)
- LOGN, $clog2(N), derived; not overridden

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin transform; sampled only in IDLE
- mode_in  in  1  0 = forward, 1 = inverse; sampled with accepted start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle completion pulse
- iNTT_mode  out  1  latched direction, drives butterfly select
- rd_en  out  1  read/twiddle request valid
- rd_addr_a  out  LOGN  A coefficient address
- rd_addr_b  out  LOGN  B coefficient address
- tw_idx  out  LOGN-1  twiddle ROM index
- wr_en  out  1  write-back valid
- wr_addr_a  out  LOGN  A' destination
- wr_addr_b  out  LOGN  B' destination
- stage  out  $clog2(LOGN)+1  current stage index (debug)

## Operation
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN occurs on start. On that edge the block latches mode_in into iNTT_mode and clears stage s and butterfly counter c. Start is ignored in every other state.
- In RUN, rd_en=1 every cycle, with c running from 0 to N/2-1. The outputs are:
  - k = c & (2^s − 1)
  - rd_addr_a = c with a 0 bit inserted at position s
  - rd_addr_b = rd_addr_a | 2^s
  - tw_idx = k << (LOGN−1−s)
- RUN→DRAIN occurs when c = N/2−1.
- DRAIN lasts RD_LAT+BF_LAT cycles with rd_en=0. It then goes to RUN with s+1 and c=0, or to DONE if s = LOGN−1.
- DONE lasts one cycle: done=1, then the FSM returns to IDLE.
- Write-back uses a delay line of depth RD_LAT+BF_LAT carrying {rd_en, rd_addr_a, rd_addr_b}. Its outputs are wr_en, wr_addr_a and wr_addr_b.
- Direction affects only iNTT_mode. The address and twiddle sequences are identical in both directions. There is no n⁻¹ scaling.
- iNTT_mode holds its value after done until the next accepted start.

## Timing
- Reset (asynchronous): FSM goes to IDLE and the delay line is cleared. Every output is 0, including iNTT_mode, stage, wr_en and done.
- Reset mid-run aborts the run immediately; no further rd_en or wr_en is issued.
- With start accepted in cycle 0:
  - The first rd_en is in cycle 1.
  - The first wr_en is in cycle 1+RD_LAT+BF_LAT.
  - done is in cycle 1 + LOGN·(N/2+RD_LAT+BF_LAT).
  - The last wr_en is in the final DRAIN cycle.
- RAM contract: a write in cycle w is visible to a read in cycle ≥ w+1. The drain length guarantees this across stage boundaries.
- wr_en never overlaps rd_en across stages. Within a stage they overlap, always on disjoint addresses.

## Configuration
- NTT_STAGE_CTRL_PERF_EN: adds output cycles (32 bits). It is cleared at accepted start, increments every cycle busy=1, and holds after done. Reset value is 0.
- Without the macro, the port and counter are absent. All other behaviour is identical.

## Structure
- Package ntt_pkg holds:
  - ctrl_state_t enum (IDLE, RUN, DRAIN, DONE)
  - an insert_zero_bit(c, s) function
  - the shared width constant W
- The natural sub-module is ntt_addr_delay: a parameterised, reset-cleared shift register of {valid, addr_a, addr_b} with depth RD_LAT+BF_LAT.

## Test plan
- **Reset:** assert reset mid-cycle with no clock → all outputs 0 immediately.
- **Forward schedule, N=8, defaults, start in cycle 0:** (a,b,tw) per stage must be:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - done pulses in cycle 19 and busy is low from cycle 19.
- **Write-back alignment:** each wr_en/wr_addr pair equals the rd_en/rd_addr pair 2 cycles earlier. No read of an address occurs in or before the cycle of its previous-stage write.
- **Inverse run and start handling:** mode_in=1 at start, then mode_in toggled and start pulsed during RUN → iNTT_mode stays 1 throughout, the schedule is identical to forward, and the extra start is ignored.
- **Reset mid-run:** reset in cycle 8, then restart → no wr_en after reset, and the new run begins at stage 0, c=0, completing in 19 cycles.
- **With NTT_STAGE_CTRL_PERF_EN, N=8:** cycles = 18 after done. With BF_LAT=2, done arrives in cycle 22.
